top_level_dec: RTL and testbench
================================

# top_level_dec

Self-contained SEC-DED Hamming decoder engine with an embedded byte-wide data memory. After reset is released it reads 15 possibly corrupted 16-bit codewords from memory, corrects single-bit errors, flags double-bit errors, writes 15 decoded 16-bit result words back into the same memory, and raises `done`. It is the top level of the program-2 datapath. The bench loads inputs and reads outputs through hierarchical access to the memory instance.

## Interface
- No parameters. Fixed constants: 15 words, input base byte address 30, output base byte address 0.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low. Low = hold in reset. The first rising edge of `clk` with `reset` high starts the run.
- `done` output 1: high once all 15 results are written; held high until the next reset.
- Internal memory instance named `dm1`, containing array `core` of 256 × 8-bit entries.
  - Memory is never cleared by reset.
  - Reads are combinational; writes are synchronous.
  - Contents must be externally writable and readable by hierarchical reference `DUT.dm1.core[n]`.

## Operation
- Input word i (i = 0..14):
  - bits [7:0] at `core[30+2i]`.
  - bits [15:8] at `core[31+2i]`.
- Codeword layout, bit position p = 0..15:
  - p0 = overall parity; p1, p2, p4, p8 = Hamming parity bits.
  - Data: d1 at bit 3, d4..d2 at bits 7..5, d11..d5 at bits 15..9.
- Syndrome s[3:0]:
  - s[k] = XOR of all codeword bits at positions 1..15 whose index has bit k set.
  - Equivalently, s = XOR of the indices of all set bits.
- P = XOR of all 16 bits.
- Classification:
  - s==0, P==0: no error. Flag = 2'b00, data unchanged.
  - P==1: single error. Flag = 2'b01.
    - If s != 0, invert codeword bit s before extracting data.
    - If s == 0, the error is in p0 and the data is unchanged.
  - s!=0, P==0: double error. Flag = 2'b10, data extracted uncorrected.
- Result word: {flag[1:0], 3'b000, d[11:1]}.
  - Low byte → `core[2i]`.
  - High byte → `core[2i+1]`.
- Bytes outside 0..29 and outside 30..59 (the inputs) are never written.

## Timing
- FSM states: IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, NEXT, FIN.
- While `reset` is low:
  - state = IDLE, word index = 0, `done` = 0.
  - No memory writes occur.
- Sequence after release:
  - IDLE → RD_LO on the first edge with `reset` high.
  - RD_LO → RD_HI → DECODE → WR_LO → WR_HI → NEXT, one cycle each.
  - NEXT increments the index and returns to RD_LO if index < 14; otherwise it goes to FIN.
- FIN: `done` = 1 (registered output); stays in FIN until `reset` goes low.
- Latency: 6 cycles per word, 90 cycles plus 1 start cycle; `done` asserts within 100 cycles of release.
- Each write cycle writes exactly one byte.
- Reset mid-run:
  - Abort immediately, with no further writes and `done` = 0.
  - Partially written outputs remain. Inputs are unaffected, so a re-run produces identical final results.
- `done` never pulses before all 30 output bytes are written.

## Test plan
- Clean word 16'h000F (d = 11'h001) at bytes 30/31 → word 0 = 16'h0001, and `done` asserts.
- Single error at a data bit: 16'h002F (bit 5 flipped) → 16'h4001.
- Single error at the overall parity bit: 16'h000E → 16'h4001.
- Single error at bit 15: 16'h7FFF (from 16'hFFFF, d = 11'h7FF) → 16'h47FF.
- Double error at bits 5 and 9: 16'h022F → 16'h8013, MSB = 1.
- Full run of 15 random words with mixed 0/1/2-bit errors:
  - Every output pair matches the golden model.
  - Bytes 60..255 are unchanged.
  - Asserting reset low mid-run, then releasing it, still yields all correct results and `done` = 1.

Source files
------------

// File: rtl/top_level_dec.sv
// SEC-DED Hamming decoder engine with embedded byte memory.
// Decodes 15 codewords at bytes 30..59 into result words at bytes 0..29.
package top_level_dec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    DECODE,
    WR_LO,
    WR_HI,
    NEXT,
    FIN
  } state_t;

  typedef struct packed {
    logic [1:0]  flag;
    logic [10:0] data;
  } dec_t;

  localparam logic [3:0] LAST_IDX = 4'd14;
  localparam logic [7:0] IN_BASE  = 8'd30;
  localparam logic [7:0] OUT_BASE = 8'd0;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_SEC = 2'b01;
  localparam logic [1:0] FLAG_DED = 2'b10;

endpackage

module data_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] core [256];

  always_ff @(posedge clk) begin
    if (we) begin
      core[wr_addr] <= wr_data;
    end
  end

  assign rd_data = core[rd_addr];

endmodule

module decode_stage
  import top_level_dec_pkg::*;
(
  input  logic [15:0] cw,
  output logic [1:0]  flag,
  output logic [10:0] data
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fix;
  dec_t        res;

  always_comb begin
    syn = '0;
    for (int p = 1; p < 16; p++) begin
      if (cw[p]) begin
        syn = syn ^ 4'(p);
      end
    end
  end

  assign par = ^cw;

  // Syndrome 0 with odd parity means p0 itself flipped.
  always_comb begin
    fix      = cw;
    res.flag = FLAG_OK;
    unique case (1'b1)
      par: begin
        res.flag = FLAG_SEC;
        if (syn != 4'd0) begin
          fix = cw ^ (16'd1 << syn);
        end
      end
      (!par && (syn != 4'd0)): begin
        res.flag = FLAG_DED;
      end
      default: begin
        res.flag = FLAG_OK;
      end
    endcase
    res.data = {fix[15:9], fix[7:5], fix[3]};
  end

  assign flag = res.flag;
  assign data = res.data;

endmodule

module top_level_dec
  import top_level_dec_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic done
);

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic [15:0] res_q;

  logic [7:0]  idx2;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        we;
  logic [1:0]  flag;
  logic [10:0] data;

  assign idx2    = {3'b000, idx, 1'b0};
  assign rd_addr = IN_BASE + idx2
                 + {7'd0, state == RD_HI};
  assign wr_addr = OUT_BASE + idx2
                 + {7'd0, state == WR_HI};
  assign wr_data = (state == WR_HI) ?
                   res_q[15:8] : res_q[7:0];

  // Gate with reset so an aborting edge never writes.
  assign we = reset &
              ((state == WR_LO) || (state == WR_HI));

  data_mem dm1 (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  decode_stage u_dec (
    .cw   ({hi_q, lo_q}),
    .flag (flag),
    .data (data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= 4'd0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= RD_LO;
        end
        RD_LO: begin
          lo_q  <= rd_data;
          state <= RD_HI;
        end
        RD_HI: begin
          hi_q  <= rd_data;
          state <= DECODE;
        end
        DECODE: begin
          res_q <= {flag, 3'b000, data};
          state <= WR_LO;
        end
        WR_LO: begin
          state <= WR_HI;
        end
        WR_HI: begin
          state <= NEXT;
        end
        NEXT: begin
          if (idx < LAST_IDX) begin
            idx   <= idx + 4'd1;
            state <= RD_LO;
          end else begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_level_dec.sv
// Directed + random bench for top_level_dec.
// Memory is preloaded/inspected hierarchically; results checked via a queue.
module tb_top_level_dec;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;

  top_level_dec DUT (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] exp_q [$];
  logic [15:0] exp_arr [15];
  logic [15:0] cw_arr [15];
  logic [7:0]  bg [256];
  logic [7:0]  snap [30];

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    logic [3:0]  s;
    cw = '0;
    s  = '0;
    cw[3]    = d[0];
    cw[7:5]  = d[3:1];
    cw[15:9] = d[10:4];
    for (int p = 1; p < 16; p++)
      if (cw[p]) s = s ^ 4'(p);
    cw[1] = s[0];
    cw[2] = s[1];
    cw[4] = s[2];
    cw[8] = s[3];
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_results(input string run);
    logic [15:0] e;
    logic [15:0] got;
    for (int i = 0; i < 15; i++) begin
      got = {DUT.dm1.core[2*i+1], DUT.dm1.core[2*i]};
      if (exp_q.size() == 0) begin
        chk($sformatf("%s_q_empty%0d", run, i), 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_word%0d", run, i), got, e);
      end
    end
  endtask

  task automatic check_untouched(input string run);
    int mism;
    mism = 0;
    for (int n = 30; n < 256; n++)
      if (DUT.dm1.core[n] !== bg[n]) mism++;
    chk({run, "_untouched"}, mism, 0);
  endtask

  initial begin
    int cyc;
    int nerr;
    int p1;
    int p2;
    logic [10:0] d;
    logic [15:0] cw;
    int mism;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", done, 0);

    cw_arr[0] = 16'h000F; exp_arr[0] = 16'h0001;
    cw_arr[1] = 16'h002F; exp_arr[1] = 16'h4001;
    cw_arr[2] = 16'h000E; exp_arr[2] = 16'h4001;
    cw_arr[3] = 16'h7FFF; exp_arr[3] = 16'h47FF;
    cw_arr[4] = 16'h022F; exp_arr[4] = 16'h8013;
    for (int i = 5; i < 15; i++) begin
      d    = 11'($urandom_range(0, 2047));
      nerr = i % 3;
      cw   = encode(d);
      p1   = $urandom_range(0, 15);
      p2   = (p1 + $urandom_range(1, 15)) % 16;
      if (nerr >= 1) cw[p1] = ~cw[p1];
      if (nerr == 2) cw[p2] = ~cw[p2];
      cw_arr[i] = cw;
      if (nerr == 0)
        exp_arr[i] = {5'b00000, d};
      else if (nerr == 1)
        exp_arr[i] = {5'b01000, d};
      else
        exp_arr[i] = {5'b10000, cw[15:9], cw[7:5], cw[3]};
    end

    for (int n = 0; n < 256; n++)
      bg[n] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 15; i++) begin
      bg[30+2*i] = cw_arr[i][7:0];
      bg[31+2*i] = cw_arr[i][15:8];
      exp_q.push_back(exp_arr[i]);
    end
    for (int n = 0; n < 256; n++)
      DUT.dm1.core[n] <= bg[n];
    @(posedge clk);

    @(negedge clk);
    reset = 1'b1;
    wait_done(cyc);
    chk("latency", cyc, 91);
    check_results("run1");
    check_untouched("run1");
    repeat (5) @(posedge clk);
    #1;
    chk("done_held", done, 1);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("done_cleared", done, 0);
    for (int n = 0; n < 30; n++)
      DUT.dm1.core[n] <= 8'h00;
    @(posedge clk);
    for (int i = 0; i < 15; i++)
      exp_q.push_back(exp_arr[i]);

    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_done", done, 0);
    chk("partial_word0",
        {DUT.dm1.core[1], DUT.dm1.core[0]}, exp_arr[0]);
    for (int n = 0; n < 30; n++)
      snap[n] = DUT.dm1.core[n];
    repeat (5) @(posedge clk);
    #1;
    mism = 0;
    for (int n = 0; n < 30; n++)
      if (DUT.dm1.core[n] !== snap[n]) mism++;
    chk("no_write_in_reset", mism, 0);
    chk("done_in_reset", done, 0);

    @(negedge clk);
    reset = 1'b1;
    wait_done(cyc);
    chk("latency_rerun", cyc, 91);
    check_results("run2");
    check_untouched("run2");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
